// File: rtl/fxp_accum.sv
// fxp_accum: streaming signed fixed-point group accumulator with output Q-format conversion.
// Define FXP_ACCUM_SAT_EN to clamp the accumulator on overflow; otherwise it wraps.
module fxp_accum #(
   parameter int WII   = 8,
   parameter int WIF   = 8,
   parameter int WG    = 4,
   parameter int WOI   = 12,
   parameter int WOF   = 4,
   parameter int ROUND = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [WII+WIF-1:0]   i_data,
   input  logic                 i_last,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [WOI+WOF-1:0]   o_data,
   output logic                 o_overflow
);

   localparam int WI  = WII + WIF;
   localparam int WA  = WII + WG + WIF;
   localparam int WO  = WOI + WOF;
   localparam int UP  = (WOF >= WIF) ? WOF - WIF : 0;
   localparam int DN  = (WOF >= WIF) ? 0 : WIF - WOF;
   localparam int RSH = (DN > 0) ? DN - 1 : 0;
   localparam int WT  = WA + 1 + UP;
   localparam int WC  = ((WT > WO) ? WT : WO) + 1;

   localparam bit RND_EN = (ROUND != 0) && (DN > 0);
   localparam logic signed [WT-1:0] RND_C = RND_EN ? (WT'(1) <<< RSH) : '0;
   localparam logic signed [WC-1:0] MAX_C = (WC'(1) <<< (WO - 1)) - WC'(1);
   localparam logic signed [WC-1:0] MIN_C = -(WC'(1) <<< (WO - 1));
   localparam logic [WA-1:0] ACC_MAX = {1'b0, {(WA-1){1'b1}}};
   localparam logic [WA-1:0] ACC_MIN = {1'b1, {(WA-1){1'b0}}};

   logic signed [WA-1:0] acc_q, acc_d;
   logic                 ovfSticky_q, ovfSticky_d;
   logic                 oValid_q, oValid_d;
   logic [WO-1:0]        oData_q, oData_d;
   logic                 oOvf_q, oOvf_d;

   logic                 inAccept;
   logic signed [WA:0]   sumWide;
   logic                 stepOvf;
   logic signed [WA-1:0] sumSel;
   logic signed [WT-1:0] sumExt;
   logic signed [WT-1:0] scaled;
   logic signed [WC-1:0] scaledC;
   logic                 convHi;
   logic                 convLo;
   logic [WO-1:0]        convData;

   // A waiting result never blocks a sample in the cycle it is consumed.
   assign i_ready  = !oValid_q || o_ready;
   assign inAccept = i_valid && i_ready;

   assign sumWide = {acc_q[WA-1], acc_q} + {{(WG+1){i_data[WI-1]}}, i_data};
   assign stepOvf = sumWide[WA] ^ sumWide[WA-1];

   // Range handling of one accumulation step: clamp or two's-complement wrap.
   always_comb begin
      sumSel = sumWide[WA-1:0];
`ifdef FXP_ACCUM_SAT_EN
      if (stepOvf) begin
         sumSel = sumWide[WA] ? ACC_MIN : ACC_MAX;
      end
`endif
   end

   // Requantise to the output fraction width, then clip to the output integer range.
   assign sumExt   = {{(WT-WA){sumSel[WA-1]}}, sumSel};
   assign scaled   = ((sumExt + RND_C) >>> DN) <<< UP;
   assign scaledC  = {{(WC-WT){scaled[WT-1]}}, scaled};
   assign convHi   = scaledC > MAX_C;
   assign convLo   = scaledC < MIN_C;
   assign convData = convHi ? MAX_C[WO-1:0] :
                     convLo ? MIN_C[WO-1:0] : scaledC[WO-1:0];

   // Next-state: a last sample closes the group and loads the output register.
   always_comb begin
      acc_d       = acc_q;
      ovfSticky_d = ovfSticky_q;
      oValid_d    = oValid_q && !o_ready;
      oData_d     = oData_q;
      oOvf_d      = oOvf_q;
      if (inAccept) begin
         if (i_last) begin
            oData_d     = convData;
            oOvf_d      = ovfSticky_q || stepOvf || convHi || convLo;
            oValid_d    = 1'b1;
            acc_d       = '0;
            ovfSticky_d = 1'b0;
         end else begin
            acc_d       = sumSel;
            ovfSticky_d = ovfSticky_q || stepOvf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         ovfSticky_q <= 1'b0;
         oValid_q    <= 1'b0;
         oData_q     <= '0;
         oOvf_q      <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         ovfSticky_q <= ovfSticky_d;
         oValid_q    <= oValid_d;
         oData_q     <= oData_d;
         oOvf_q      <= oOvf_d;
      end
   end

   assign o_valid    = oValid_q;
   assign o_data     = oData_q;
   assign o_overflow = oOvf_q;

endmodule

// File: tb/tb_fxp_accum.sv
// tb_fxp_accum: directed self-checking bench for fxp_accum, with a rounding and a truncating instance.
// Expected values follow FXP_ACCUM_SAT_EN when it is defined for the build.
module tb_fxp_accum;

   logic        clk, rst, iValid, iLast, oReady;
   logic [15:0] iData;
   logic        iReady, oValid, oOverflow;
   logic [15:0] oData;
   logic        tIReady, tOValid, tOOverflow;
   logic [15:0] tOData;

   int checkCount = 0;
   int passCount  = 0;

`ifdef FXP_ACCUM_SAT_EN
   localparam logic [15:0] OVF_R  = 16'h7FFF;
   localparam logic [15:0] OVF_T  = 16'h7FFF;
   localparam logic [15:0] CONT_R = 16'h7800;
`else
   localparam logic [15:0] OVF_R  = 16'h87FF;
   localparam logic [15:0] OVF_T  = 16'h87FE;
   localparam logic [15:0] CONT_R = 16'h7FFF;
`endif

   fxp_accum dut (
      .clk(clk), .rst(rst), .i_valid(iValid), .i_ready(iReady), .i_data(iData),
      .i_last(iLast), .o_valid(oValid), .o_ready(oReady), .o_data(oData),
      .o_overflow(oOverflow)
   );

   fxp_accum #(.ROUND(0)) dutTrunc (
      .clk(clk), .rst(rst), .i_valid(iValid), .i_ready(tIReady), .i_data(iData),
      .i_last(iLast), .o_valid(tOValid), .o_ready(oReady), .o_data(tOData),
      .o_overflow(tOOverflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Presents one sample and returns 1 time unit after the edge that accepts it.
   task automatic applyStimulus(input logic [15:0] data, input logic last);
      int guard;
      iValid = 1'b1;
      iData  = data;
      iLast  = last;
      @(negedge clk);
      guard = 0;
      while (!iReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!iReady) begin
         checkCount++;
         $display("[TB] FAIL accept_timeout: i_ready=%b required 1", iReady);
      end
      @(posedge clk);
      #1;
      iValid = 1'b0;
      iLast  = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checkCount++;
      if (oValid !== 1'b0) $display("[TB] FAIL reset_o_valid: got %b required 0", oValid);
      else passCount++;
      checkCount++;
      if (oData !== 16'h0000) $display("[TB] FAIL reset_o_data: got %h required 0000", oData);
      else passCount++;
      checkCount++;
      if (oOverflow !== 1'b0) $display("[TB] FAIL reset_o_overflow: got %b required 0", oOverflow);
      else passCount++;
      checkCount++;
      if (iReady !== 1'b1) $display("[TB] FAIL reset_i_ready: got %b required 1", iReady);
      else passCount++;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic_sum;
      oReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0180, i == 3);
         if (i < 3) begin
            checkCount++;
            if (oValid !== 1'b0) $display("[TB] FAIL basic_early_valid[%0d]: got %b required 0", i, oValid);
            else passCount++;
         end
      end
      checkCount++;
      if (oValid !== 1'b1) $display("[TB] FAIL basic_valid: got %b required 1", oValid);
      else passCount++;
      checkCount++;
      if (oData !== 16'h0060) $display("[TB] FAIL basic_data: got %h required 0060", oData);
      else passCount++;
      checkCount++;
      if (oOverflow !== 1'b0) $display("[TB] FAIL basic_overflow: got %b required 0", oOverflow);
      else passCount++;
      @(posedge clk);
      #1;
      checkCount++;
      if (oValid !== 1'b0) $display("[TB] FAIL basic_consumed: got %b required 0", oValid);
      else passCount++;
   endtask

   task automatic test_rounding;
      logic [15:0] samples [2] = '{16'h0008, 16'hFFF8};
      logic [15:0] expR    [2] = '{16'h0001, 16'h0000};
      logic [15:0] expT    [2] = '{16'h0000, 16'hFFFF};
      for (int i = 0; i < 2; i++) begin
         applyStimulus(samples[i], 1'b1);
         checkCount++;
         if (oValid !== 1'b1 || tOValid !== 1'b1)
            $display("[TB] FAIL round_valid[%0d]: got %b/%b required 1/1", i, oValid, tOValid);
         else passCount++;
         checkCount++;
         if (oData !== expR[i]) $display("[TB] FAIL round_half_up[%0d]: got %h required %h", i, oData, expR[i]);
         else passCount++;
         checkCount++;
         if (tOData !== expT[i]) $display("[TB] FAIL round_trunc[%0d]: got %h required %h", i, tOData, expT[i]);
         else passCount++;
      end
   endtask

   task automatic test_bounds;
      for (int i = 0; i < 16; i++) applyStimulus(16'h8000, i == 15);
      checkCount++;
      if (oData !== 16'h8000 || oOverflow !== 1'b0)
         $display("[TB] FAIL neg_bound: got %h/%b required 8000/0", oData, oOverflow);
      else passCount++;
      checkCount++;
      if (tOData !== 16'h8000 || tOOverflow !== 1'b0)
         $display("[TB] FAIL neg_bound_trunc: got %h/%b required 8000/0", tOData, tOOverflow);
      else passCount++;
      for (int i = 0; i < 16; i++) applyStimulus(16'h7FFF, 1'b0);
      applyStimulus(16'h0008, 1'b1);
      checkCount++;
      if (oData !== 16'h7FFF || oOverflow !== 1'b1)
         $display("[TB] FAIL conv_sat_round: got %h/%b required 7fff/1", oData, oOverflow);
      else passCount++;
      checkCount++;
      if (tOData !== 16'h7FFF || tOOverflow !== 1'b0)
         $display("[TB] FAIL conv_fit_trunc: got %h/%b required 7fff/0", tOData, tOOverflow);
      else passCount++;
   endtask

   task automatic test_acc_overflow;
      for (int i = 0; i < 17; i++) applyStimulus(16'h7FFF, i == 16);
      checkCount++;
      if (oData !== OVF_R || oOverflow !== 1'b1)
         $display("[TB] FAIL acc_ovf_round: got %h/%b required %h/1", oData, oOverflow, OVF_R);
      else passCount++;
      checkCount++;
      if (tOData !== OVF_T || tOOverflow !== 1'b1)
         $display("[TB] FAIL acc_ovf_trunc: got %h/%b required %h/1", tOData, tOOverflow, OVF_T);
      else passCount++;
      for (int i = 0; i < 17; i++) applyStimulus(16'h7FFF, 1'b0);
      applyStimulus(16'h8000, 1'b1);
      checkCount++;
      if (oData !== CONT_R || oOverflow !== 1'b1)
         $display("[TB] FAIL acc_ovf_continue: got %h/%b required %h/1", oData, oOverflow, CONT_R);
      else passCount++;
      applyStimulus(16'h0100, 1'b1);
      checkCount++;
      if (oData !== 16'h0010 || oOverflow !== 1'b0)
         $display("[TB] FAIL acc_ovf_recover: got %h/%b required 0010/0", oData, oOverflow);
      else passCount++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] samples [5] = '{16'h0100, 16'h0100, 16'h0080, 16'h0300, 16'h0100};
      logic        lasts   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        expV    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] expD    [5] = '{16'h0000, 16'h0020, 16'h0008, 16'h0000, 16'h0040};
      oReady = 1'b1;
      @(posedge clk);
      #1;
      oReady = 1'b0;
      applyStimulus(16'h0100, 1'b1);
      iValid = 1'b1;
      iData  = 16'h0200;
      iLast  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkCount++;
         if (oValid !== 1'b1 || oData !== 16'h0010)
            $display("[TB] FAIL hold_result[%0d]: got %b/%h required 1/0010", c, oValid, oData);
         else passCount++;
         checkCount++;
         if (iReady !== 1'b0) $display("[TB] FAIL hold_i_ready[%0d]: got %b required 0", c, iReady);
         else passCount++;
         @(posedge clk);
         #1;
      end
      oReady = 1'b1;
      @(negedge clk);
      checkCount++;
      if (iReady !== 1'b1 || tIReady !== 1'b1)
         $display("[TB] FAIL release_i_ready: got %b/%b required 1/1", iReady, tIReady);
      else passCount++;
      @(posedge clk);
      #1;
      checkCount++;
      if (oValid !== 1'b1 || oData !== 16'h0020)
         $display("[TB] FAIL release_load: got %b/%h required 1/0020", oValid, oData);
      else passCount++;
      for (int i = 0; i < 5; i++) begin
         iValid = 1'b1;
         iData  = samples[i];
         iLast  = lasts[i];
         @(posedge clk);
         #1;
         checkCount++;
         if (oValid !== expV[i]) $display("[TB] FAIL b2b_valid[%0d]: got %b required %b", i, oValid, expV[i]);
         else passCount++;
         if (expV[i]) begin
            checkCount++;
            if (oData !== expD[i]) $display("[TB] FAIL b2b_data[%0d]: got %h required %h", i, oData, expD[i]);
            else passCount++;
         end
      end
      iValid = 1'b0;
      iLast  = 1'b0;
   endtask

   task automatic test_reset_mid_group;
      oReady = 1'b1;
      applyStimulus(16'h0100, 1'b0);
      applyStimulus(16'h0100, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkCount++;
      if (oValid !== 1'b0 || oData !== 16'h0000 || oOverflow !== 1'b0)
         $display("[TB] FAIL midreset_outputs: got %b/%h/%b required 0/0000/0", oValid, oData, oOverflow);
      else passCount++;
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(16'h0100, 1'b1);
      checkCount++;
      if (oValid !== 1'b1 || oData !== 16'h0010 || oOverflow !== 1'b0)
         $display("[TB] FAIL midreset_next_group: got %b/%h/%b required 1/0010/0", oValid, oData, oOverflow);
      else passCount++;
   endtask

   initial begin
      rst    = 1'b1;
      iValid = 1'b0;
      iLast  = 1'b0;
      iData  = 16'h0000;
      oReady = 1'b0;
      test_reset();
      test_basic_sum();
      test_rounding();
      test_bounds();
      test_acc_overflow();
      test_back_to_back();
      test_reset_mid_group();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
